// File: rtl/mp3_frame_sequencer_if.sv
// Byte-stream input and parsed-frame outputs of the MP3 frame sequencer.
// The slave modport is the sequencer side; the master modport is the byte source and consumer side.
interface mp3_frame_sequencer_if #(
  parameter int MAX_FRAME = 1441
);
  localparam int LEN_W = $clog2(MAX_FRAME + 1);

  logic [7:0]       axiid;
  logic             axiiv;
  logic [7:0]       si_axiid;
  logic             si_axiiv;
  logic [31:0]      si_counter;
  logic [7:0]       md_axiid;
  logic             md_axiiv;
  logic             stereo;
  logic             crc_present;
  logic             padding;
  logic [3:0]       bitrate_idx;
  logic [1:0]       samplerate_idx;
  logic [LEN_W-1:0] frame_len;
  logic             frame_start;
  logic             si_done;
  logic             frame_done;
  logic             sync_lost;

  modport master (
    output axiid, axiiv,
    input  si_axiid, si_axiiv, si_counter, md_axiid, md_axiiv,
    input  stereo, crc_present, padding, bitrate_idx, samplerate_idx, frame_len,
    input  frame_start, si_done, frame_done, sync_lost
  );

  modport slave (
    input  axiid, axiiv,
    output si_axiid, si_axiiv, si_counter, md_axiid, md_axiiv,
    output stereo, crc_present, padding, bitrate_idx, samplerate_idx, frame_len,
    output frame_start, si_done, frame_done, sync_lost
  );
endinterface

// File: rtl/mp3_frame_sequencer.sv
// MPEG-1 Layer III frame sequencer: finds sync, latches header fields and splits
// each frame into side-info and main-data byte streams, all outputs registered.
//
// state | meaning
// HUNT  | searching for FF + 1111101x (idx 1 = first FF seen)
// HDR   | idx 0/1 follow-on sync check, idx 2/3 header fields
// CRC   | dropping the 2 CRC bytes
// SIDE  | forwarding 17 (mono) or 32 (stereo) side-info bytes
// MAIN  | forwarding main data up to frame_len-1
module mp3_frame_sequencer #(
  parameter int MAX_FRAME = 1441
) (
  input logic                clk,
  input logic                rst,
  mp3_frame_sequencer_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_FRAME + 1);
  localparam logic [10:0] IDX_MAX = 11'h7ff;

  typedef enum logic [2:0] {HUNT, HDR, CRC, SIDE, MAIN} state_t;

  state_t           state_q, state_d;
  logic [10:0]      idx_q, idx_d;
  logic [4:0]       sub_q, sub_d;
  logic             prot_q, prot_d;
  logic [7:0]       si_data_d, md_data_d;
  logic             si_v_d, md_v_d;
  logic [31:0]      si_cnt_d;
  logic             stereo_d, crc_d, pad_d;
  logic [3:0]       br_d;
  logic [1:0]       sr_d;
  logic [LEN_W-1:0] len_d;
  logic             start_d, si_done_d, done_d, lost_d;
  logic             byte_ff, is_sync1, bad_hdr;

  // floor(144000 * kbps / fs) for the three MPEG-1 sample rates
  function automatic logic [10:0] frame_bytes(input logic [3:0] br, input logic [1:0] sr);
    logic [10:0] l44, l48, l32;
    case (br)
      4'd1:    begin l44 = 11'd104;  l48 = 11'd96;  l32 = 11'd144;  end
      4'd2:    begin l44 = 11'd130;  l48 = 11'd120; l32 = 11'd180;  end
      4'd3:    begin l44 = 11'd156;  l48 = 11'd144; l32 = 11'd216;  end
      4'd4:    begin l44 = 11'd182;  l48 = 11'd168; l32 = 11'd252;  end
      4'd5:    begin l44 = 11'd208;  l48 = 11'd192; l32 = 11'd288;  end
      4'd6:    begin l44 = 11'd261;  l48 = 11'd240; l32 = 11'd360;  end
      4'd7:    begin l44 = 11'd313;  l48 = 11'd288; l32 = 11'd432;  end
      4'd8:    begin l44 = 11'd365;  l48 = 11'd336; l32 = 11'd504;  end
      4'd9:    begin l44 = 11'd417;  l48 = 11'd384; l32 = 11'd576;  end
      4'd10:   begin l44 = 11'd522;  l48 = 11'd480; l32 = 11'd720;  end
      4'd11:   begin l44 = 11'd626;  l48 = 11'd576; l32 = 11'd864;  end
      4'd12:   begin l44 = 11'd731;  l48 = 11'd672; l32 = 11'd1008; end
      4'd13:   begin l44 = 11'd835;  l48 = 11'd768; l32 = 11'd1152; end
      4'd14:   begin l44 = 11'd1044; l48 = 11'd960; l32 = 11'd1440; end
      default: begin l44 = 11'd0;    l48 = 11'd0;   l32 = 11'd0;    end
    endcase
    case (sr)
      2'd0:    frame_bytes = l44;
      2'd1:    frame_bytes = l48;
      2'd2:    frame_bytes = l32;
      default: frame_bytes = 11'd0;
    endcase
  endfunction

  assign byte_ff  = (bus.axiid == 8'hFF);
  assign is_sync1 = (bus.axiid[7:1] == 7'b1111101);
  assign bad_hdr  = (bus.axiid[7:4] == 4'd0) || (bus.axiid[7:4] == 4'd15) ||
                    (bus.axiid[3:2] == 2'd3);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sub_d     = sub_q;
    prot_d    = prot_q;
    si_data_d = bus.si_axiid;
    md_data_d = bus.md_axiid;
    si_v_d    = 1'b0;
    md_v_d    = 1'b0;
    si_cnt_d  = (state_q == SIDE) ? bus.si_counter : 32'd0;
    stereo_d  = bus.stereo;
    crc_d     = bus.crc_present;
    pad_d     = bus.padding;
    br_d      = bus.bitrate_idx;
    sr_d      = bus.samplerate_idx;
    len_d     = bus.frame_len;
    start_d   = 1'b0;
    si_done_d = 1'b0;
    done_d    = 1'b0;
    lost_d    = 1'b0;
    if (bus.axiiv) begin
      case (state_q)
        HUNT: begin
          if (idx_q == 11'd1 && is_sync1) begin
            start_d = 1'b1;
            prot_d  = bus.axiid[0];
            state_d = HDR;
            idx_d   = 11'd2;
          end else begin
            idx_d = byte_ff ? 11'd1 : 11'd0;
          end
        end
        HDR: begin
          case (idx_q)
            11'd0: begin
              if (byte_ff) idx_d = 11'd1;
              else begin
                lost_d  = 1'b1;
                state_d = HUNT;
              end
            end
            11'd1: begin
              if (is_sync1) begin
                start_d = 1'b1;
                prot_d  = bus.axiid[0];
                idx_d   = 11'd2;
              end else begin
                lost_d  = 1'b1;
                state_d = HUNT;
                idx_d   = byte_ff ? 11'd1 : 11'd0;
              end
            end
            11'd2: begin
              br_d  = bus.axiid[7:4];
              sr_d  = bus.axiid[3:2];
              pad_d = bus.axiid[1];
              len_d = LEN_W'(frame_bytes(bus.axiid[7:4], bus.axiid[3:2]) + 11'(bus.axiid[1]));
              // a reserved header is just noise that looked like sync, not a lost stream
              if (bad_hdr) begin
                state_d = HUNT;
                idx_d   = 11'd0;
              end else begin
                idx_d = 11'd3;
              end
            end
            default: begin
              stereo_d = (bus.axiid[7:6] != 2'b11);
              crc_d    = ~prot_q;
              idx_d    = 11'd4;
              sub_d    = 5'd0;
              state_d  = prot_q ? SIDE : CRC;
            end
          endcase
        end
        CRC: begin
          idx_d = idx_q + 11'd1;
          if (sub_q == 5'd1) begin
            sub_d   = 5'd0;
            state_d = SIDE;
          end else begin
            sub_d = sub_q + 5'd1;
          end
        end
        SIDE: begin
          si_v_d    = 1'b1;
          si_data_d = bus.axiid;
          si_cnt_d  = 32'(sub_q) + 32'd4;
          idx_d     = idx_q + 11'd1;
          if (sub_q == (bus.stereo ? 5'd31 : 5'd16)) begin
            si_done_d = 1'b1;
            sub_d     = 5'd0;
            state_d   = MAIN;
          end else begin
            sub_d = sub_q + 5'd1;
          end
        end
        MAIN: begin
          md_v_d    = 1'b1;
          md_data_d = bus.axiid;
          if (idx_q == 11'(bus.frame_len - 1'b1)) begin
            done_d  = 1'b1;
            state_d = HDR;
            idx_d   = 11'd0;
          end else if (idx_q == IDX_MAX) begin
            lost_d  = 1'b1;
            state_d = HUNT;
            idx_d   = 11'd0;
          end else begin
            idx_d = idx_q + 11'd1;
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = 11'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= HUNT;
      idx_q              <= 11'd0;
      sub_q              <= 5'd0;
      prot_q             <= 1'b0;
      bus.si_axiid       <= 8'd0;
      bus.si_axiiv       <= 1'b0;
      bus.si_counter     <= 32'd0;
      bus.md_axiid       <= 8'd0;
      bus.md_axiiv       <= 1'b0;
      bus.stereo         <= 1'b0;
      bus.crc_present    <= 1'b0;
      bus.padding        <= 1'b0;
      bus.bitrate_idx    <= 4'd0;
      bus.samplerate_idx <= 2'd0;
      bus.frame_len      <= '0;
      bus.frame_start    <= 1'b0;
      bus.si_done        <= 1'b0;
      bus.frame_done     <= 1'b0;
      bus.sync_lost      <= 1'b0;
    end else begin
      state_q            <= state_d;
      idx_q              <= idx_d;
      sub_q              <= sub_d;
      prot_q             <= prot_d;
      bus.si_axiid       <= si_data_d;
      bus.si_axiiv       <= si_v_d;
      bus.si_counter     <= si_cnt_d;
      bus.md_axiid       <= md_data_d;
      bus.md_axiiv       <= md_v_d;
      bus.stereo         <= stereo_d;
      bus.crc_present    <= crc_d;
      bus.padding        <= pad_d;
      bus.bitrate_idx    <= br_d;
      bus.samplerate_idx <= sr_d;
      bus.frame_len      <= len_d;
      bus.frame_start    <= start_d;
      bus.si_done        <= si_done_d;
      bus.frame_done     <= done_d;
      bus.sync_lost      <= lost_d;
    end
  end
endmodule

// File: tb/tb_mp3_frame_sequencer.sv
// Directed bench for mp3_frame_sequencer: hand-built frames checked byte by byte
// against positional expectations derived from the header values.
module tb_mp3_frame_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mp3_frame_sequencer_if bus();
  mp3_frame_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit v, input logic [7:0] d);
    bus.axiiv = v;
    bus.axiid = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] hdr_word();
    return {bus.stereo, bus.crc_present, bus.padding, bus.bitrate_idx, bus.samplerate_idx};
  endfunction

  // Sends FF b1 b2 b3 + payload; no_ff skips byte 0 when sync was already started.
  task automatic send_frame(input string name, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input int len, input int crc_n,
                            input int si_n, input int md_n, input bit gaps, input bit no_ff);
    logic [7:0] d;
    int si_seen, md_seen, bad, len_seen, g, si_lo, md_lo;
    si_seen  = 0;
    md_seen  = 0;
    bad      = 0;
    len_seen = 0;
    si_lo    = 4 + crc_n;
    md_lo    = si_lo + si_n;
    for (int i = (no_ff ? 1 : 0); i < len; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          tick(1'b0, 8'h00);
          if (bus.si_axiiv || bus.md_axiiv || bus.frame_start || bus.si_done ||
              bus.frame_done || bus.sync_lost) bad++;
        end
      end
      case (i)
        0:       d = 8'hFF;
        1:       d = b1;
        2:       d = b2;
        3:       d = b3;
        default: d = 8'(i * 13) ^ 8'hA5;
      endcase
      tick(1'b1, d);
      if (bus.si_axiiv) si_seen++;
      if (bus.md_axiiv) md_seen++;
      if (i == 3) len_seen = int'(bus.frame_len);
      if (bus.frame_start !== (i == 1)) bad++;
      if (bus.sync_lost !== 1'b0) bad++;
      if (bus.si_done !== (i == md_lo - 1)) bad++;
      if (bus.frame_done !== (i == len - 1)) bad++;
      if (i >= si_lo && i < md_lo) begin
        if (bus.si_axiiv !== 1'b1 || bus.md_axiiv !== 1'b0 || bus.si_axiid !== d ||
            bus.si_counter !== 32'(i - crc_n)) bad++;
      end else if (i >= md_lo) begin
        if (bus.md_axiiv !== 1'b1 || bus.si_axiiv !== 1'b0 || bus.md_axiid !== d ||
            bus.si_counter !== 32'd0) bad++;
      end else begin
        if (bus.si_axiiv !== 1'b0 || bus.md_axiiv !== 1'b0 || bus.si_counter !== 32'd0) bad++;
      end
    end
    chk({name, "_frame_len"}, len_seen, len);
    chk({name, "_si_bytes"}, si_seen, si_n);
    chk({name, "_md_bytes"}, md_seen, md_n);
    chk({name, "_byte_errs"}, bad, 0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.axiiv = 1'b0;
    bus.axiid = 8'h00;
    repeat (3) tick(1'b0, 8'h00);
    chk("rst_data", {bus.si_axiid, bus.si_axiiv, bus.md_axiid, bus.md_axiiv}, 0);
    chk("rst_si_counter", bus.si_counter, 0);
    chk("rst_hdr", {hdr_word(), bus.frame_len}, 0);
    chk("rst_pulses", {bus.frame_start, bus.si_done, bus.frame_done, bus.sync_lost}, 0);
    rst = 1'b0;

    send_frame("mono", 8'hFB, 8'h94, 8'hC0, 384, 0, 17, 363, 1'b0, 1'b0);
    chk("mono_hdr", hdr_word(), {1'b0, 1'b0, 1'b0, 4'd9, 2'd1});
    send_frame("st_crc", 8'hFA, 8'h90, 8'h00, 417, 2, 32, 379, 1'b0, 1'b0);
    chk("st_crc_hdr", hdr_word(), {1'b1, 1'b1, 1'b0, 4'd9, 2'd0});
    send_frame("pad441", 8'hFB, 8'h92, 8'h00, 418, 0, 32, 382, 1'b0, 1'b0);
    chk("pad441_hdr", hdr_word(), {1'b1, 1'b0, 1'b1, 4'd9, 2'd0});
    send_frame("r32k", 8'hFB, 8'h98, 8'h00, 576, 0, 32, 540, 1'b0, 1'b0);
    chk("r32k_hdr", hdr_word(), {1'b1, 1'b0, 1'b0, 4'd9, 2'd2});

    send_frame("gap_mono", 8'hFB, 8'h94, 8'hC0, 384, 0, 17, 363, 1'b1, 1'b0);
    send_frame("gap_st_crc", 8'hFA, 8'h90, 8'h00, 417, 2, 32, 379, 1'b1, 1'b0);

    tick(1'b1, 8'h00);
    chk("lost_on_00", bus.sync_lost, 1);
    send_frame("reacq", 8'hFB, 8'h94, 8'hC0, 384, 0, 17, 363, 1'b0, 1'b0);

    tick(1'b1, 8'hFF);
    chk("idx0_ff_no_lost", bus.sync_lost, 0);
    tick(1'b1, 8'hFF);
    chk("idx1_ff_lost", bus.sync_lost, 1);
    send_frame("ff_as_first", 8'hFB, 8'h94, 8'hC0, 384, 0, 17, 363, 1'b0, 1'b1);

    tick(1'b1, 8'h12);
    chk("lost_before_garbage", bus.sync_lost, 1);
    tick(1'b1, 8'hFF);
    chk("hunt_ff_quiet", {bus.sync_lost, bus.frame_start}, 0);
    send_frame("ff_ff_fb", 8'hFB, 8'h94, 8'hC0, 384, 0, 17, 363, 1'b0, 1'b0);

    tick(1'b1, 8'hFF);
    tick(1'b1, 8'hFB);
    chk("bad_hdr_start", bus.frame_start, 1);
    tick(1'b1, 8'hF4);
    chk("bad_hdr_no_lost", bus.sync_lost, 0);
    tick(1'b1, 8'hC0);
    tick(1'b1, 8'h33);
    chk("bad_hdr_quiet", {bus.si_axiiv, bus.md_axiiv, bus.sync_lost, bus.frame_start}, 0);
    send_frame("after_bad", 8'hFB, 8'h94, 8'hC0, 384, 0, 17, 363, 1'b0, 1'b0);

    tick(1'b1, 8'hFF);
    tick(1'b1, 8'hFB);
    tick(1'b1, 8'h94);
    tick(1'b1, 8'hC0);
    for (int i = 4; i < 10; i++) tick(1'b1, 8'(i + 8'h40));
    chk("pre_rst_si_counter", bus.si_counter, 9);
    rst = 1'b1;
    tick(1'b1, 8'h4A);
    chk("midrst_data", {bus.si_axiid, bus.si_axiiv, bus.md_axiid, bus.md_axiiv}, 0);
    chk("midrst_si_counter", bus.si_counter, 0);
    chk("midrst_hdr", {hdr_word(), bus.frame_len}, 0);
    chk("midrst_pulses", {bus.frame_start, bus.si_done, bus.frame_done, bus.sync_lost}, 0);
    rst = 1'b0;
    send_frame("post_rst", 8'hFA, 8'h90, 8'h00, 417, 2, 32, 379, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
